// File: rtl/data_reg_bank.sv
// Per-core data-register bank: NCH channel registers with write/inc/clear,
// a registered lowest-index-wins bus read port and a one-shot memory fill engine.

module data_reg_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             inc,
  input  logic             clr,
  input  logic             fill_we,
  input  logic [WIDTH-1:0] bin,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (wr) begin
      q   <= bin;
      ovf <= 1'b0;
    end else if (fill_we) begin
      q   <= fill_data;
      ovf <= 1'b0;
    end else if (inc) begin
      q <= q + WIDTH'(1);
      if (&q) ovf <= 1'b1;
    end
  end

endmodule

module data_reg_bank #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic [NCH-1:0]   wr,
  input  logic [NCH-1:0]   inc,
  input  logic [NCH-1:0]   clr,
  input  logic [NCH-1:0]   ldbus,
  output logic [WIDTH-1:0] bout,
  output logic             bout_oe,
  output logic             bus_conflict,
  output logic [NCH-1:0]   ovf,
  input  logic             fill_start,
  input  logic [2:0]       fill_ch,
  output logic             mem_req,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_data,
  output logic             fill_busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE} fill_st_t;

  localparam logic [3:0] NCH_W = 4'(NCH);

  fill_st_t                    state;
  logic [2:0]                  fill_sel;
  logic [WIDTH-1:0]            fill_data;
  logic [NCH-1:0]              fill_we;
  logic [NCH-1:0][WIDTH-1:0]   q;
  logic [WIDTH-1:0]            sel_d;
  logic                        sel_v;
  logic                        ch_ok;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign fill_we[i] = (state == S_WRITE) && (fill_sel == 3'(i));
    data_reg_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (wr[i]),
      .inc       (inc[i]),
      .clr       (clr[i]),
      .fill_we   (fill_we[i]),
      .bin       (bin),
      .fill_data (fill_data),
      .q         (q[i]),
      .ovf       (ovf[i])
    );
  end

  // Scan from the top so the lowest requesting index is the last assignment.
  always_comb begin
    sel_d = '0;
    sel_v = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ldbus[i]) begin
        sel_v = 1'b1;
        sel_d = q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bout         <= '0;
      bout_oe      <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      bout         <= sel_d;
      bout_oe      <= sel_v;
      bus_conflict <= |(ldbus & (ldbus - NCH'(1)));
    end
  end

  assign ch_ok = ({1'b0, fill_ch} < NCH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fill_sel  <= '0;
      fill_data <= '0;
      mem_req   <= 1'b0;
      fill_busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (fill_start && ch_ok) begin
          state     <= S_REQ;
          fill_sel  <= fill_ch;
          mem_req   <= 1'b1;
          fill_busy <= 1'b1;
        end
        S_REQ: if (mem_ack) begin
          state     <= S_WRITE;
          fill_data <= mem_data;
          mem_req   <= 1'b0;
        end
        S_WRITE: begin
          state     <= S_IDLE;
          fill_busy <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          mem_req   <= 1'b0;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_reg_bank.sv
// Scoreboarded bench for data_reg_bank: a reference model predicts bus/ovf
// results each cycle, expectations are queued at drive time and popped after the edge.

module tb_data_reg_bank;

  localparam int WIDTH = 16;
  localparam int NCH   = 4;

  typedef struct {
    logic             oe;
    logic [WIDTH-1:0] d;
    logic             cf;
  } bus_exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] bin;
  logic [NCH-1:0]   wr, inc, clr, ldbus;
  logic [WIDTH-1:0] bout;
  logic             bout_oe, bus_conflict;
  logic [NCH-1:0]   ovf;
  logic             fill_start;
  logic [2:0]       fill_ch;
  logic             mem_req, mem_ack, fill_busy;
  logic [WIDTH-1:0] mem_data;

  data_reg_bank #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .wr(wr), .inc(inc), .clr(clr),
    .ldbus(ldbus), .bout(bout), .bout_oe(bout_oe), .bus_conflict(bus_conflict),
    .ovf(ovf), .fill_start(fill_start), .fill_ch(fill_ch), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] mreg [NCH];
  logic [NCH-1:0]   movf;
  logic             mf_we;
  int               mf_ch;
  logic [WIDTH-1:0] mf_d;
  bus_exp_t         sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mreg[i] = '0;
    movf = '0;
    mf_we = 1'b0;
    sb.delete();
  endtask

  // Predict the bus result from pre-edge state, advance the model, then clock and compare.
  task automatic tick(input string tag);
    bus_exp_t e;
    e.oe = 1'b0;
    e.d  = '0;
    e.cf = ($countones(ldbus) > 1);
    for (int i = 0; i < NCH; i++)
      if (ldbus[i] && !e.oe) begin
        e.oe = 1'b1;
        e.d  = mreg[i];
      end
    sb.push_back(e);
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) begin
        mreg[i] = '0; movf[i] = 1'b0;
      end else if (wr[i]) begin
        mreg[i] = bin; movf[i] = 1'b0;
      end else if (mf_we && mf_ch == i) begin
        mreg[i] = mf_d; movf[i] = 1'b0;
      end else if (inc[i]) begin
        if (mreg[i] == '1) movf[i] = 1'b1;
        mreg[i] = mreg[i] + 16'd1;
      end
    end
    mf_we = 1'b0;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_oe"},   {31'd0, bout_oe},      {31'd0, e.oe});
      chk({tag, "_bout"}, {16'd0, bout},         {16'd0, e.d});
      chk({tag, "_cf"},   {31'd0, bus_conflict}, {31'd0, e.cf});
    end
    chk({tag, "_ovf"}, {28'd0, ovf}, {28'd0, movf});
  endtask

  task automatic idle_in();
    wr = '0; inc = '0; clr = '0; ldbus = '0;
    fill_start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bin = '0; fill_ch = '0; mem_data = '0;
    idle_in();
    model_reset();
    #23;
    chk("rst_bout", {16'd0, bout}, 32'd0);
    chk("rst_oe", {31'd0, bout_oe}, 32'd0);
    chk("rst_cf", {31'd0, bus_conflict}, 32'd0);
    chk("rst_ovf", {28'd0, ovf}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, fill_busy}, 32'd0);
    rst_n = 1'b1;

    // write then read back over the bus
    wr = 4'b0010; bin = 16'h1234; tick("wr1");
    idle_in(); ldbus = 4'b0010; tick("rd1");
    idle_in(); tick("idle");

    // wrap sets ovf, a later write clears it
    wr = 4'b0001; bin = 16'hFFFF; tick("wr0");
    idle_in(); inc = 4'b0001; tick("inc0_wrap");
    idle_in(); ldbus = 4'b0001; tick("rd0");
    idle_in(); wr = 4'b0001; bin = 16'h0005; tick("wr0_clrovf");

    // clr beats wr and inc
    idle_in(); clr = 4'b0100; wr = 4'b0100; inc = 4'b0100; bin = 16'h00AA; tick("prio2");
    idle_in(); ldbus = 4'b0100; tick("rd2");

    // two readers: lowest index wins, conflict flagged for one cycle
    idle_in(); wr = 4'b0010; bin = 16'h0011; tick("wr1b");
    idle_in(); wr = 4'b0100; bin = 16'h0022; tick("wr2b");
    idle_in(); ldbus = 4'b0110; tick("conflict");
    idle_in(); tick("conflict_gone");

    // randomized mix, biased toward near-wrap data
    for (int n = 0; n < 300; n++) begin
      idle_in();
      bin = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      wr    = NCH'($urandom) & NCH'($urandom);
      inc   = NCH'($urandom);
      clr   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      ldbus = NCH'($urandom);
      tick("rand");
    end

    // fill: out-of-range channel ignored, then a real fill into ch3 with ovf set
    idle_in(); wr = 4'b1000; bin = 16'hFFFF; tick("wr3");
    idle_in(); inc = 4'b1000; tick("inc3_wrap");
    idle_in(); fill_start = 1'b1; fill_ch = 3'd5; tick("fill_bad");
    chk("fill_bad_busy", {31'd0, fill_busy}, 32'd0);
    chk("fill_bad_req", {31'd0, mem_req}, 32'd0);
    idle_in(); fill_start = 1'b1; fill_ch = 3'd3; tick("fill_c1");
    chk("fill_req1", {31'd0, mem_req}, 32'd1);
    chk("fill_busy1", {31'd0, fill_busy}, 32'd1);
    idle_in(); fill_start = 1'b1; fill_ch = 3'd1; tick("fill_c2");
    chk("fill_req2", {31'd0, mem_req}, 32'd1);
    idle_in(); tick("fill_c3");
    chk("fill_req3", {31'd0, mem_req}, 32'd1);
    idle_in(); mem_ack = 1'b1; mem_data = 16'hBEEF; tick("fill_ack");
    chk("fill_req_ack", {31'd0, mem_req}, 32'd0);
    chk("fill_busy_ack", {31'd0, fill_busy}, 32'd1);
    idle_in(); mf_we = 1'b1; mf_ch = 3; mf_d = 16'hBEEF; tick("fill_wr");
    chk("fill_busy_done", {31'd0, fill_busy}, 32'd0);
    chk("fill_req_done", {31'd0, mem_req}, 32'd0);
    idle_in(); ldbus = 4'b1000; tick("rd3");
    idle_in(); ldbus = 4'b0010; tick("rd1_untouched");

    // reset in the middle of a fill abandons it
    idle_in(); fill_start = 1'b1; fill_ch = 3'd2; tick("fill2_start");
    idle_in();
    chk("fill2_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, fill_busy}, 32'd0);
    chk("midrst_oe", {31'd0, bout_oe}, 32'd0);
    chk("midrst_ovf", {28'd0, ovf}, 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    mem_ack = 1'b1; mem_data = 16'hDEAD; tick("late_ack");
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_busy", {31'd0, fill_busy}, 32'd0);
    idle_in(); tick("post1");
    tick("post2");
    ldbus = 4'b0100; tick("rd2_after_rst");
    idle_in(); ldbus = 4'b1111; tick("rd_all_zero");
    idle_in(); tick("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
